// File: rtl/reg_dump_uart_tx.sv
// Register dump initiator: walks reg_sel 0..NUM_REGS-1 and sends each 32-bit value as four
// UART 8N1 frames, MSB byte first. Optional sync/checksum framing under `REG_DUMP_HEADER_EN.
module reg_dump_uart_tx #(
    parameter int CLK_DIV  = 868,
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        txd,
    output logic        busy,
    output logic        done
);
    localparam int          CW   = $clog2(CLK_DIV);
    localparam logic [4:0]  LAST = 5'(NUM_REGS - 1);

    typedef enum logic [2:0] {IDLE, SEL, LATCH, START, DATA, STOP, NEXT, FIN} state_t;

    state_t         state, state_next;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [1:0]     byte_idx;
    logic [31:0]    shadow;
    logic [7:0]     tx_byte;
    logic           wrap;

    assign wrap = (cnt == CW'(CLK_DIV - 1));

`ifdef REG_DUMP_HEADER_EN
    // The two extra cycles sit at the front: the first SEL/LATCH pass after start only
    // launches the 0xA5 frame, then SEL/LATCH repeat for register 0. The checksum frame
    // starts straight from the last NEXT and its stop bit goes straight to FIN.
    logic       hdr_pend, hdr_frm, sum_frm;
    logic [7:0] csum;

    assign tx_byte = hdr_frm ? 8'hA5 : (sum_frm ? csum : shadow[{byte_idx, 3'b000} +: 8]);
`else
    assign tx_byte = shadow[{byte_idx, 3'b000} +: 8];
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // txd is decoded from registered state so reset forces the line idle at once.
    always_comb begin
        state_next = state;
        txd        = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE:  if (start) state_next = SEL;
            SEL:   state_next = LATCH;
            LATCH: state_next = START;
            START: begin
                txd = 1'b0;
                if (wrap) state_next = DATA;
            end
            DATA: begin
                txd = tx_byte[bit_idx];
                if (wrap && bit_idx == 3'd7) state_next = STOP;
            end
            STOP: if (wrap) begin
                state_next = (byte_idx != 2'd0) ? START : NEXT;
`ifdef REG_DUMP_HEADER_EN
                if (hdr_frm) state_next = SEL;
                if (sum_frm) state_next = FIN;
`endif
            end
            NEXT: begin
                if (reg_sel != LAST) state_next = SEL;
`ifdef REG_DUMP_HEADER_EN
                else                 state_next = START;
`else
                else                 state_next = FIN;
`endif
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shadow   <= '0;
            reg_sel  <= '0;
            busy     <= 1'b0;
`ifdef REG_DUMP_HEADER_EN
            hdr_pend <= 1'b0;
            hdr_frm  <= 1'b0;
            sum_frm  <= 1'b0;
            csum     <= '0;
`endif
        end else begin
            // Held at zero outside frames, so every START begins a fresh bit period.
            if ((state == START || state == DATA || state == STOP) && !wrap) cnt <= cnt + CW'(1);
            else                                                           cnt <= '0;
            if (state == DATA && wrap) bit_idx <= bit_idx + 3'd1;
            case (state)
                IDLE: if (start) begin
                    reg_sel <= '0;
                    busy    <= 1'b1;
`ifdef REG_DUMP_HEADER_EN
                    hdr_pend <= 1'b1;
                    csum     <= '0;
`endif
                end
                LATCH: begin
                    shadow   <= reg_data;
                    byte_idx <= 2'd3;
`ifdef REG_DUMP_HEADER_EN
                    if (hdr_pend) begin
                        hdr_pend <= 1'b0;
                        hdr_frm  <= 1'b1;
                        byte_idx <= 2'd0;
                    end else begin
                        csum <= csum ^ reg_data[31:24] ^ reg_data[23:16] ^ reg_data[15:8] ^ reg_data[7:0];
                    end
`endif
                end
                STOP: if (wrap) begin
                    if (byte_idx != 2'd0) byte_idx <= byte_idx - 2'd1;
`ifdef REG_DUMP_HEADER_EN
                    hdr_frm <= 1'b0;
`endif
                end
                NEXT: begin
                    if (reg_sel != LAST) reg_sel <= reg_sel + 5'd1;
`ifdef REG_DUMP_HEADER_EN
                    else                 sum_frm <= 1'b1;
`endif
                end
                FIN: begin
                    busy    <= 1'b0;
                    reg_sel <= '0;
`ifdef REG_DUMP_HEADER_EN
                    sum_frm <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_dump_uart_tx.sv
// Randomized bench for reg_dump_uart_tx: a UART receiver model decodes txd and the
// expected byte stream and dump timing are derived from the register file contents.
module tb_reg_dump_uart_tx;
    localparam int D  = 4;
    localparam int NR = 32;
`ifdef REG_DUMP_HEADER_EN
    localparam int HOFS = 10*D + 2;
    localparam int T    = NR*(3 + 40*D) + 20*D + 2;
`else
    localparam int HOFS = 0;
    localparam int T    = NR*(3 + 40*D);
`endif

    logic        clk = 1'b0, rstn = 1'b0, start = 1'b0;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        txd, busy, done;

    logic [31:0] regs [NR];
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_val = '0;
    logic [7:0]  rxq [$];
    int          ferr = 0, ndone = 0;
    int          checks = 0, errors = 0;

    assign reg_data = ovr_en ? ovr_val : regs[reg_sel];

    reg_dump_uart_tx #(.CLK_DIV(D), .NUM_REGS(NR)) dut (
        .clk(clk), .rstn(rstn), .start(start), .reg_sel(reg_sel),
        .reg_data(reg_data), .txd(txd), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) ndone++;

    // UART receiver: detect start, sample mid-bit, LSB first.
    initial begin : uart_mon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rstn && txd === 1'b0) begin
                repeat (D/2) @(negedge clk);
                if (txd === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (D) @(negedge clk);
                        b[i] = txd;
                    end
                    repeat (D) @(negedge clk);
                    if (txd !== 1'b1) ferr++;
                    rxq.push_back(b);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: plain, 1: extra start pulses while busy, 2: reg_data changes mid-frame of reg 0
    task automatic run_dump(input string tag, input int mode);
        logic [7:0]  exp [$];
        logic [7:0]  cs;
        logic [31:0] v;
        int k, fall, bad_busy, base, nd0, fe0;
        bit got_done, first_bad;
        cs = '0;
        for (int r = 0; r < NR; r++) begin
            v = (mode == 2 && r > 0) ? 32'hDEADBEEF : regs[r];
            for (int j = 3; j >= 0; j--) begin
                exp.push_back(v[8*j +: 8]);
                cs ^= v[8*j +: 8];
            end
        end
`ifdef REG_DUMP_HEADER_EN
        exp.push_front(8'hA5);
        exp.push_back(cs);
`endif
        base = rxq.size(); nd0 = ndone; fe0 = ferr;
        k = 0; fall = -1; bad_busy = 0; got_done = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        fork
            begin
                while (!got_done && k <= T + 50) begin
                    @(negedge clk);
                    if (k == 0) start = 1'b0;
                    if (fall < 0 && txd === 1'b0) fall = k;
                    if (done === 1'b1) got_done = 1;
                    else begin
                        if (busy !== 1'b1) bad_busy++;
                        k++;
                    end
                end
            end
            begin
                if (mode == 1) begin
                    repeat (10) @(negedge clk);  start = 1'b1; @(negedge clk); start = 1'b0;
                    repeat (489) @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
                    repeat (3499) @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
                end else if (mode == 2) begin
                    repeat (HOFS + 2 + D + 10) @(negedge clk);
                    ovr_val = 32'hDEADBEEF;
                    ovr_en  = 1'b1;
                end
            end
        join
        chk({tag, " done_cycle"}, k, T);
        chk({tag, " txd_fall"}, fall, 2);
        chk({tag, " busy_during"}, bad_busy, 0);
        @(negedge clk);
        chk({tag, " done_after"}, done, 0);
        chk({tag, " busy_after"}, busy, 0);
        chk({tag, " reg_sel_after"}, reg_sel, 0);
        repeat (200) @(negedge clk);
        ovr_en = 1'b0;
        chk({tag, " done_pulses"}, ndone - nd0, 1);
        chk({tag, " busy_idle"}, busy, 0);
        chk({tag, " nbytes"}, rxq.size() - base, exp.size());
        chk({tag, " framing"}, ferr - fe0, 0);
        first_bad = 0;
        for (int i = 0; i < exp.size() && !first_bad; i++) begin
            if (base + i < rxq.size()) begin
                if (rxq[base + i] !== exp[i]) first_bad = 1;
                chk($sformatf("%s byte%0d", tag, i), rxq[base + i], exp[i]);
            end
        end
    endtask

    initial begin
        // reset and idle
        repeat (3) begin
            @(negedge clk);
            chk("rst_outs", {txd, busy, done, reg_sel}, {1'b1, 1'b0, 1'b0, 5'd0});
        end
        rstn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_outs", {txd, busy, done, reg_sel}, {1'b1, 1'b0, 1'b0, 5'd0});
        end

        for (int i = 0; i < NR; i++) regs[i] = 32'h1000_0000 + i;
        run_dump("seq", 0);

        for (int i = 0; i < NR; i++) regs[i] = $urandom;
        regs[0] = 32'h12345678;
        run_dump("shadow", 2);

        for (int i = 0; i < NR; i++) regs[i] = $urandom;
        run_dump("busy_start", 1);

        // reset in the middle of a data bit of reg 5 (MSB byte forced to zero so txd is low)
        for (int i = 0; i < NR; i++) regs[i] = $urandom;
        regs[5][31:24] = 8'h00;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (HOFS + 5*(3 + 40*D) + 2 + D + 4) @(negedge clk);
        chk("midrst_pre_txd", txd, 0);
        chk("midrst_pre_busy", busy, 1);
        chk("midrst_pre_sel", reg_sel, 5);
        rstn = 1'b0;
        #1;
        chk("midrst_txd", txd, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_sel", reg_sel, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (12*D) @(negedge clk);
        chk("midrst_idle_txd", txd, 1);
        for (int i = 0; i < NR; i++) regs[i] = $urandom;
        run_dump("post_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
